// File: rtl/aes_out_serializer_pkg.sv
// Shared widths, FSM state type and byte-select helper for the AES output serializer.
package aes_out_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FIRST  = 2'd1,
    S_SECOND = 2'd2
  } state_e;

  function automatic logic [BYTE_W-1:0] pick_byte(input logic [WORD_W-1:0] w, input logic hi);
    return hi ? w[15:8] : w[7:0];
  endfunction

endpackage

// File: rtl/aes_out_serializer_if.sv
// Word-in / byte-out bus of the AES output serializer.
interface aes_out_serializer_if #(
  parameter int unsigned DEPTH = 4
);
  import aes_out_pkg::*;

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic              in_word_valid;
  logic [WORD_W-1:0] in_word;
  logic              out_word_ready;
  logic              out_byte_valid;
  logic              in_byte_ready;
  logic [BYTE_W-1:0] out_byte;
  logic              out_last;
  logic [CW-1:0]     out_count;
  logic              out_overflow;

  modport slave (
    input  in_word_valid, in_word, in_byte_ready,
    output out_word_ready, out_byte_valid, out_byte, out_last, out_count, out_overflow
  );

  modport master (
    output in_word_valid, in_word, in_byte_ready,
    input  out_word_ready, out_byte_valid, out_byte, out_last, out_count, out_overflow
  );

endinterface

// File: rtl/aes_word_fifo.sv
// Synchronous word FIFO; writes while full and reads while empty are ignored.
module aes_word_fifo
  import aes_out_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WORD_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [WORD_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_wr, do_rd;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // Fullness comes from the registered count, so a same-cycle pop never frees a slot
  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(do_wr) - CW'(do_rd);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/aes_out_serializer.sv
// Buffers 16-bit encoder words and emits them as byte pairs on a valid/ready interface.
module aes_out_serializer
  import aes_out_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                 in_clka,
  input  logic                 in_restart_n,
  aes_out_serializer_if.slave  bus
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] hold_q, hold_d;
  logic [BYTE_W-1:0] byte_q, byte_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              ovf_q, ovf_d;

  logic              rd_en;
  logic [WORD_W-1:0] rd_data;
  logic [CW-1:0]     count;
  logic              full, empty;
  logic              xfer;

  aes_word_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (in_clka),
    .rst_n   (in_restart_n),
    .wr_en   (bus.in_word_valid),
    .wr_data (bus.in_word),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  assign xfer               = valid_q & bus.in_byte_ready;
  assign bus.out_word_ready = in_restart_n & ~full;
  assign bus.out_byte_valid = valid_q;
  assign bus.out_byte       = byte_q;
  assign bus.out_last       = last_q;
  assign bus.out_count      = count;
  assign bus.out_overflow   = ovf_q;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    byte_d  = byte_q;
    valid_d = valid_q;
    last_d  = last_q;
    rd_en   = 1'b0;
    ovf_d   = ovf_q | (bus.in_word_valid & full);

    unique case (state_q)
      S_IDLE: begin
        rd_en = ~empty;
      end
      S_FIRST: begin
        if (xfer) begin
          state_d = S_SECOND;
          byte_d  = pick_byte(hold_q, ~MSB_FIRST);
          last_d  = 1'b1;
        end
      end
      S_SECOND: begin
        if (xfer) begin
          if (!empty) begin
            rd_en = 1'b1;
          end else begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            byte_d  = '0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
        byte_d  = '0;
      end
    endcase

    // Shared pop path for IDLE and the bubble-free SECOND->FIRST hand-off
    if (rd_en) begin
      hold_d  = rd_data;
      state_d = S_FIRST;
      byte_d  = pick_byte(rd_data, MSB_FIRST);
      valid_d = 1'b1;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge in_clka) begin
    if (!in_restart_n) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_aes_out_serializer.sv
// Scenario bench for aes_out_serializer: MSB-first and LSB-first instances, scoreboarded bytes.
module tb_aes_out_serializer;
  import aes_out_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  aes_out_serializer_if #(.DEPTH(4)) bus ();
  aes_out_serializer_if #(.DEPTH(4)) bus_l ();

  aes_out_serializer #(.DEPTH(4), .MSB_FIRST(1'b1)) u_dut (
    .in_clka(clk), .in_restart_n(rst_n), .bus(bus)
  );

  aes_out_serializer #(.DEPTH(4), .MSB_FIRST(1'b0)) u_dut_l (
    .in_clka(clk), .in_restart_n(rst_n), .bus(bus_l)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [15:0] w, input bit msb);
    if (msb) begin
      exp_q.push_back({1'b0, w[15:8]});
      exp_q.push_back({1'b1, w[7:0]});
    end else begin
      exp_q.push_back({1'b0, w[7:0]});
      exp_q.push_back({1'b1, w[15:8]});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_word_valid = 1'b0;   bus.in_word = '0;   bus.in_byte_ready = 1'b1;
    bus_l.in_word_valid = 1'b0; bus_l.in_word = '0; bus_l.in_byte_ready = 1'b1;
    tick();
    tick();
    n_tests++;
    if ({bus.out_byte_valid, bus.out_last, bus.out_overflow, bus.out_word_ready, bus.out_count, bus.out_byte} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%0b l=%0b ovf=%0b wr=%0b cnt=%0d byte=%h required all zero",
               bus.out_byte_valid, bus.out_last, bus.out_overflow, bus.out_word_ready, bus.out_count, bus.out_byte);
    end
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (bus.out_word_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL word_ready_after_reset: got %0b required 1", bus.out_word_ready);
    end
    tick();
  endtask

  task automatic test_single();
    int cyc;
    logic [8:0] e;
    bus.in_word_valid = 1'b1; bus.in_word = 16'hA76F; push_word(16'hA76F, 1'b1);
    tick();
    bus.in_word_valid = 1'b0;
    n_tests++;
    if ({bus.out_byte_valid, bus.out_count} !== {1'b0, 3'd1}) begin
      n_fail++;
      $display("FAIL single_written: got v=%0b cnt=%0d required v=0 cnt=1", bus.out_byte_valid, bus.out_count);
    end
    tick();
    n_tests++;
    if ({bus.out_byte_valid, bus.out_byte, bus.out_last, bus.out_count} !== {1'b1, 8'hA7, 1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL single_latency: got v=%0b byte=%h l=%0b cnt=%0d required v=1 byte=a7 l=0 cnt=0",
               bus.out_byte_valid, bus.out_byte, bus.out_last, bus.out_count);
    end
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 40) begin
      if (bus.out_byte_valid && bus.in_byte_ready) begin
        e = exp_q.pop_front();
        n_tests++;
        if ({bus.out_last, bus.out_byte} !== e) begin
          n_fail++;
          $display("FAIL single_byte: got l=%0b byte=%h required l=%0b byte=%h", bus.out_last, bus.out_byte, e[8], e[7:0]);
        end
      end
      tick();
      cyc++;
    end
    n_tests++;
    if (cyc !== 2 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL single_cycles: got %0d cycles, %0d left, required 2 cycles, 0 left", cyc, exp_q.size());
      exp_q.delete();
    end
    n_tests++;
    if ({bus.out_byte_valid, bus.out_count} !== {1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL single_idle: got v=%0b cnt=%0d required v=0 cnt=0", bus.out_byte_valid, bus.out_count);
    end
  endtask

  task automatic test_lsb_first();
    int cyc;
    logic [8:0] e;
    bus_l.in_word_valid = 1'b1; bus_l.in_word = 16'hA76F; push_word(16'hA76F, 1'b0);
    tick();
    bus_l.in_word_valid = 1'b0;
    tick();
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 40) begin
      if (bus_l.out_byte_valid && bus_l.in_byte_ready) begin
        e = exp_q.pop_front();
        n_tests++;
        if ({bus_l.out_last, bus_l.out_byte} !== e) begin
          n_fail++;
          $display("FAIL lsb_byte: got l=%0b byte=%h required l=%0b byte=%h", bus_l.out_last, bus_l.out_byte, e[8], e[7:0]);
        end
      end
      tick();
      cyc++;
    end
    n_tests++;
    if (cyc !== 2 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL lsb_cycles: got %0d cycles, %0d left, required 2 cycles, 0 left", cyc, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_back_pressure();
    int cyc;
    int peak;
    logic [8:0] e;
    bus.in_byte_ready = 1'b0;
    bus.in_word_valid = 1'b1; bus.in_word = 16'h3B6B; push_word(16'h3B6B, 1'b1);
    tick();
    bus.in_word = 16'hF57A; push_word(16'hF57A, 1'b1);
    tick();
    bus.in_word_valid = 1'b0;
    peak = int'(bus.out_count);
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if ({bus.out_byte_valid, bus.out_last, bus.out_byte} !== {1'b1, 1'b0, 8'h3B}) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got v=%0b l=%0b byte=%h required v=1 l=0 byte=3b",
                 i, bus.out_byte_valid, bus.out_last, bus.out_byte);
      end
      tick();
    end
    bus.in_byte_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 40) begin
      if (int'(bus.out_count) > peak) peak = int'(bus.out_count);
      if (bus.out_byte_valid && bus.in_byte_ready) begin
        e = exp_q.pop_front();
        n_tests++;
        if ({bus.out_last, bus.out_byte} !== e) begin
          n_fail++;
          $display("FAIL bp_byte: got l=%0b byte=%h required l=%0b byte=%h", bus.out_last, bus.out_byte, e[8], e[7:0]);
        end
      end
      tick();
      cyc++;
    end
    n_tests++;
    if (cyc !== 4 || exp_q.size() != 0 || peak !== 1) begin
      n_fail++;
      $display("FAIL bp_flow: got %0d cycles, %0d left, peak %0d required 4 cycles, 0 left, peak 1", cyc, exp_q.size(), peak);
      exp_q.delete();
    end
  endtask

  task automatic test_simul_wr_pop();
    int cyc;
    logic [8:0] e;
    bus.in_byte_ready = 1'b0;
    bus.in_word_valid = 1'b1;
    bus.in_word = 16'h1111; push_word(16'h1111, 1'b1); tick();
    bus.in_word = 16'h2222; push_word(16'h2222, 1'b1); tick();
    bus.in_word = 16'h3333; push_word(16'h3333, 1'b1); tick();
    bus.in_word_valid = 1'b0;
    n_tests++;
    if (bus.out_count !== 3'd2) begin
      n_fail++;
      $display("FAIL simul_setup_count: got %0d required 2", bus.out_count);
    end
    bus.in_byte_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 40) begin
      bus.in_word_valid = (cyc == 1);
      if (cyc == 1) begin
        bus.in_word = 16'h4444;
        push_word(16'h4444, 1'b1);
      end
      if (bus.out_byte_valid && bus.in_byte_ready) begin
        e = exp_q.pop_front();
        n_tests++;
        if ({bus.out_last, bus.out_byte} !== e) begin
          n_fail++;
          $display("FAIL simul_byte: got l=%0b byte=%h required l=%0b byte=%h", bus.out_last, bus.out_byte, e[8], e[7:0]);
        end
      end
      tick();
      cyc++;
      if (cyc == 2) begin
        n_tests++;
        if (bus.out_count !== 3'd2) begin
          n_fail++;
          $display("FAIL simul_count: got %0d required 2", bus.out_count);
        end
      end
    end
    bus.in_word_valid = 1'b0;
    n_tests++;
    if (cyc !== 8 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL simul_cycles: got %0d cycles, %0d left, required 8 cycles, 0 left", cyc, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_full_overflow();
    int cyc;
    int exp_cnt;
    logic [8:0] e;
    bus.in_byte_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      exp_cnt = (i <= 2) ? i - 1 : i - 2;
      n_tests++;
      if ({bus.out_word_ready, bus.out_count} !== {(exp_cnt != 4), 3'(exp_cnt)}) begin
        n_fail++;
        $display("FAIL full_fill[%0d]: got wr=%0b cnt=%0d required wr=%0b cnt=%0d",
                 i, bus.out_word_ready, bus.out_count, (exp_cnt != 4), exp_cnt);
      end
      bus.in_word_valid = 1'b1;
      bus.in_word = 16'(i);
      if (i <= 5) push_word(16'(i), 1'b1);
      tick();
    end
    bus.in_word_valid = 1'b0;
    n_tests++;
    if ({bus.out_overflow, bus.out_word_ready, bus.out_count} !== {1'b1, 1'b0, 3'd4}) begin
      n_fail++;
      $display("FAIL full_overflow: got ovf=%0b wr=%0b cnt=%0d required ovf=1 wr=0 cnt=4",
               bus.out_overflow, bus.out_word_ready, bus.out_count);
    end
    bus.in_byte_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 60) begin
      if (bus.out_byte_valid && bus.in_byte_ready) begin
        e = exp_q.pop_front();
        n_tests++;
        if ({bus.out_last, bus.out_byte} !== e) begin
          n_fail++;
          $display("FAIL full_byte: got l=%0b byte=%h required l=%0b byte=%h", bus.out_last, bus.out_byte, e[8], e[7:0]);
        end
      end
      tick();
      cyc++;
    end
    n_tests++;
    if (cyc !== 10 || exp_q.size() != 0 || bus.out_byte_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL full_drain: got %0d cycles, %0d left, v=%0b required 10 cycles, 0 left, v=0",
               cyc, exp_q.size(), bus.out_byte_valid);
      exp_q.delete();
    end
    n_tests++;
    if ({bus.out_overflow, bus.out_count} !== {1'b1, 3'd0}) begin
      n_fail++;
      $display("FAIL full_sticky: got ovf=%0b cnt=%0d required ovf=1 cnt=0", bus.out_overflow, bus.out_count);
    end
  endtask

  task automatic test_reset_mid_word();
    int cyc;
    logic [8:0] e;
    bus.in_byte_ready = 1'b0;
    bus.in_word_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_word = 16'h5555 + 16'(i) * 16'h1111;
      tick();
    end
    bus.in_word_valid = 1'b0;
    bus.in_byte_ready = 1'b1;
    tick();
    n_tests++;
    if ({bus.out_byte_valid, bus.out_last, bus.out_count} !== {1'b1, 1'b1, 3'd3}) begin
      n_fail++;
      $display("FAIL mid_setup: got v=%0b l=%0b cnt=%0d required v=1 l=1 cnt=3",
               bus.out_byte_valid, bus.out_last, bus.out_count);
    end
    rst_n = 1'b0;
    tick();
    n_tests++;
    if ({bus.out_byte_valid, bus.out_last, bus.out_overflow, bus.out_count, bus.out_byte} !== 14'd0) begin
      n_fail++;
      $display("FAIL mid_reset: got v=%0b l=%0b ovf=%0b cnt=%0d byte=%h required all zero",
               bus.out_byte_valid, bus.out_last, bus.out_overflow, bus.out_count, bus.out_byte);
    end
    rst_n = 1'b1;
    bus.in_word_valid = 1'b1; bus.in_word = 16'h1234; push_word(16'h1234, 1'b1);
    tick();
    bus.in_word_valid = 1'b0;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 40) begin
      if (bus.out_byte_valid && bus.in_byte_ready) begin
        e = exp_q.pop_front();
        n_tests++;
        if ({bus.out_last, bus.out_byte} !== e) begin
          n_fail++;
          $display("FAIL mid_byte: got l=%0b byte=%h required l=%0b byte=%h", bus.out_last, bus.out_byte, e[8], e[7:0]);
        end
      end
      tick();
      cyc++;
    end
    n_tests++;
    if (exp_q.size() != 0 || bus.out_count !== 3'd0 || bus.out_byte_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_drain: got %0d left, cnt=%0d v=%0b required 0 left, cnt=0 v=0",
               exp_q.size(), bus.out_count, bus.out_byte_valid);
      exp_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_lsb_first();
    test_back_pressure();
    test_simul_wr_pop();
    test_full_overflow();
    test_reset_mid_word();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_out_serializer.md
Name: aes_out_serializer

Overview:
- Downstream stage of the AES encoder top level (top_mod).
- Captures each 16-bit encoded word the encoder produces and buffers it in a small word FIFO.
- Emits the words as 8-bit bytes on a valid/ready byte interface toward the pad/readout logic.
- The encoder cannot be back-pressured, so words arriving while the FIFO is full are dropped and flagged.

Parameters:
- DEPTH, 4, FIFO depth in 16-bit words; power of two, at least 2.
- MSB_FIRST, 1, 1 = high byte [15:8] emitted first; 0 = low byte [7:0] first.

Ports:
- in_clka  input  1  single block clock; all state updates on the rising edge.
- in_restart_n  input  1  synchronous, active-low reset.
- in_word_valid  input  1  encoder word strobe, one cycle per word.
- in_word  input  16  encoded word (encoder out_data).
- out_word_ready  output  1  FIFO not full; informational to the encoder.
- out_byte_valid  output  1  out_byte holds a valid byte.
- in_byte_ready  input  1  consumer accepts the byte this cycle.
- out_byte  output  8  serialized byte.
- out_last  output  1  marks the second byte of a word.
- out_count  output  log2(DEPTH)+1  words held in the FIFO (excludes the word in the holding register).
- out_overflow  output  1  sticky: a word was dropped.

Behaviour:
- Single clock and a synchronous, active-low reset, as decided for this block.
- Reset (in_restart_n=0 at an edge) sets:
  - FIFO pointers and count to 0; state to IDLE;
  - out_byte_valid, out_last, out_overflow, out_byte all 0;
  - out_word_ready forced to 0 while in_restart_n=0; in_word_valid ignored.
- Mid-operation reset discards all buffered and in-flight data; no partial byte survives.
- Write:
  - out_word_ready = (count != DEPTH), taken from the registered count.
  - When in_word_valid=1 and out_word_ready=1, in_word is written at the edge.
  - When in_word_valid=1 and the FIFO is full, the word is dropped and out_overflow is set to 1 until reset.
  - A pop in the same cycle does NOT make room for a write when full.
- Byte handshake: a byte transfers on an edge where out_byte_valid=1 and in_byte_ready=1.
  - out_byte, out_last and out_byte_valid stay stable while in_byte_ready=0.
- FSM states: IDLE, FIRST, SECOND.
  - IDLE: out_byte_valid=0. If count>0, pop the head word into the holding register and go to FIRST.
  - FIRST: out_byte_valid=1, out_last=0, out_byte = first byte per MSB_FIRST. On transfer, go to SECOND.
  - SECOND: out_byte_valid=1, out_last=1, out_byte = other byte. On transfer: if count>0, pop the next word and go to FIRST with no bubble; else go to IDLE.
- Latency: word written at edge N into an empty FIFO in IDLE → popped at edge N+1 → out_byte_valid=1 in the cycle after edge N+1.
- Throughput: 1 byte/cycle with in_byte_ready held high, i.e. 1 word per 2 cycles.
- Simultaneous write and pop when not full: count unchanged. Write only: count+1. Pop only: count-1.
- Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- out_byte, out_last and out_byte_valid are registered outputs, with no combinational path from in_byte_ready.

Decomposition:
- Shared package aes_out_pkg:
  - state encoding constants S_IDLE=2'd0, S_FIRST=2'd1, S_SECOND=2'd2;
  - word and byte width constants 16 and 8.
- One sub-module: aes_word_fifo, a synchronous FIFO.
  - Parameter DEPTH.
  - Ports: wr_en, wr_data, rd_en, rd_data, count, full, empty.
  - Same clock and reset as the parent.
- Serializer FSM and overflow flag live in the parent.

Test Plan:
- Reset then single word:
  - Stimulus: hold in_restart_n=0 for 2 cycles; release; one in_word=16'hA76F; in_byte_ready=1.
  - Required: 0xA7 (last=0) then 0x6F (last=1) on consecutive cycles starting 2 edges after the write; then IDLE; count returns to 0.
- MSB_FIRST=0 with the same word 16'hA76F:
  - Required: 0x6F then 0xA7, with out_last=1 on 0xA7.
- Back-pressure:
  - Stimulus: words 16'h3B6B and 16'hF57A back-to-back; in_byte_ready=0 for 3 cycles, then 1.
  - Required: 0x3B held stable for 3 cycles, then bytes 3B, 6B, F5, 7A with no bubble; count peaks at 1.
- Full and overflow, DEPTH=4:
  - Stimulus: in_byte_ready=0; write 6 words 16'h0001..16'h0006 on consecutive cycles.
  - Required: word 1 moves to the holding register; words 2–5 fill the FIFO; out_word_ready=0 once count=4; word 6 dropped; out_overflow=1 and stays 1.
  - With in_byte_ready raised, exactly bytes 00 01 … 00 05 emerge.
- Simultaneous write and pop:
  - Stimulus: with count=2, write a word on the same edge the SECOND byte transfers and the next word is popped.
  - Required: count stays 2; data order is preserved.
- Reset mid-word:
  - Stimulus: assert in_restart_n=0 while in SECOND with count=3.
  - Required: next cycle out_byte_valid=0, count=0, out_overflow=0; a new word 16'h1234 afterwards yields 12, 34.
